// File: rtl/spike_rate_decoder_if.sv
// Word-addressed register bus shared by the spike encoder and decoder.
// The host drives address/write side as master; the decoder returns registered read data.
interface spike_rate_decoder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport master (
        output mem_addr,
        output mem_wen,
        output mem_data_in,
        input  mem_data_out
    );

    modport slave (
        input  mem_addr,
        input  mem_wen,
        input  mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per channel over a window of qualified samples
// and latches the per-channel counts for the host to read over the mem_* bus.
//
// state | meaning
// IDLE  | waiting for a start with a non-zero window
// COUNT | accumulating qualified samples into the working counters
module spike_rate_decoder #(
    parameter int NUM_SPIKES  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_rate_decoder_if.slave   bus,
    input  logic [NUM_SPIKES-1:0] spikes,
    input  logic                  spike_valid,
    output logic                  busy,
    output logic                  window_done
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, COUNT} state_t;

    state_t state, state_nxt;

    logic [COUNT_WIDTH-1:0] window_reg;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   cont_reg;
    logic                   done_reg;
    logic [COUNT_WIDTH-1:0] work_cnt [NUM_SPIKES];
    logic [COUNT_WIDTH-1:0] result   [NUM_SPIKES];
    logic [DATA_WIDTH-1:0]  rd_data;

    logic ctrl_wr, win_wr, stat_wr;
    logic start_ok, abort_cnt, win_end;
    logic unused_ok;

    assign unused_ok = ^bus.mem_data_in;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                       input logic                   hit);
        return (hit && v != CNT_MAX) ? v + COUNT_WIDTH'(1) : v;
    endfunction

    assign ctrl_wr = bus.mem_wen && (bus.mem_addr == ADDR_WIDTH'(0));
    assign win_wr  = bus.mem_wen && (bus.mem_addr == ADDR_WIDTH'(1));
    assign stat_wr = bus.mem_wen && (bus.mem_addr == ADDR_WIDTH'(2));

    // Abort outranks start within the same CTRL write.
    assign start_ok  = (state == IDLE) && ctrl_wr && bus.mem_data_in[0] && !bus.mem_data_in[2]
                       && (window_reg != '0);
    assign abort_cnt = (state == COUNT) && ctrl_wr && bus.mem_data_in[2];
    // remaining is a down-counter; terminal count 1 means this sample closes the window.
    assign win_end   = (state == COUNT) && spike_valid && (remaining == COUNT_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = COUNT;
            COUNT:   if (abort_cnt || (win_end && !cont_reg)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == COUNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_reg  <= '0;
            cont_reg    <= 1'b0;
            done_reg    <= 1'b0;
            remaining   <= '0;
            window_done <= 1'b0;
        end else begin
            if (win_wr && state == IDLE) window_reg <= bus.mem_data_in[COUNT_WIDTH-1:0];
            if (ctrl_wr)                 cont_reg   <= bus.mem_data_in[1];

            if (win_end)                                done_reg <= 1'b1;
            else if (stat_wr && bus.mem_data_in[1])     done_reg <= 1'b0;

            window_done <= win_end;

            if (abort_cnt)                             remaining <= '0;
            else if (start_ok || win_end)              remaining <= window_reg;
            else if (state == COUNT && spike_valid)    remaining <= remaining - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPIKES; i++) begin
                work_cnt[i] <= '0;
                result[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPIKES; i++) begin
                if (win_end) result[i] <= sat_inc(work_cnt[i], spikes[i]);

                if (start_ok || win_end || abort_cnt)
                    work_cnt[i] <= '0;
                else if (state == COUNT && spike_valid)
                    work_cnt[i] <= sat_inc(work_cnt[i], spikes[i]);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (bus.mem_addr == ADDR_WIDTH'(1)) begin
            rd_data[COUNT_WIDTH-1:0] = window_reg;
        end else if (bus.mem_addr == ADDR_WIDTH'(2)) begin
            rd_data[0] = busy;
            rd_data[1] = done_reg;
        end else begin
            for (int i = 0; i < NUM_SPIKES; i++)
                if (bus.mem_addr == ADDR_WIDTH'(4 + i)) rd_data[COUNT_WIDTH-1:0] = result[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.mem_data_out <= '0;
        else     bus.mem_data_out <= rd_data;
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized self-checking bench for spike_rate_decoder against a per-window
// spike tally model; a second, narrow instance covers the small counter width.
module tb_spike_rate_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] spikes;
    logic        spike_valid;
    logic        busy;
    logic        window_done;

    logic [3:0]  s_spikes;
    logic        s_valid;
    logic        s_busy;
    logic        s_wd;

    int vectors    = 0;
    int miscompares = 0;
    int exp_res [32];

    always #5 clk = ~clk;

    spike_rate_decoder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    spike_rate_decoder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sbus ();

    spike_rate_decoder #(.NUM_SPIKES(32), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .spikes      (spikes),
        .spike_valid (spike_valid),
        .busy        (busy),
        .window_done (window_done)
    );

    spike_rate_decoder #(.NUM_SPIKES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COUNT_WIDTH(4)) dut_narrow (
        .clk         (clk),
        .rst         (rst),
        .bus         (sbus),
        .spikes      (s_spikes),
        .spike_valid (s_valid),
        .busy        (s_busy),
        .window_done (s_wd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.mem_addr    = 32'(a);
        bus.mem_data_in = d;
        bus.mem_wen     = 1'b1;
        tick();
        bus.mem_wen     = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        bus.mem_addr = 32'(a);
        bus.mem_wen  = 1'b0;
        tick();
        d = bus.mem_data_out;
    endtask

    task automatic s_wr(input int a, input logic [31:0] d);
        sbus.mem_addr    = 32'(a);
        sbus.mem_data_in = d;
        sbus.mem_wen     = 1'b1;
        tick();
        sbus.mem_wen     = 1'b0;
    endtask

    task automatic s_rd(input int a, output logic [31:0] d);
        sbus.mem_addr = 32'(a);
        sbus.mem_wen  = 1'b0;
        tick();
        d = sbus.mem_data_out;
    endtask

    // Drives samples until nwin windows close; the model tallies spikes per channel
    // over the first w qualified samples and expects a done pulse right after.
    // smode: 0 = 0x3, 1 = all ones, 2 = ch5 on alternate valid samples, 3 = random
    // vmode: 0 = always valid, 1 = toggling from valid, 2 = random
    task automatic run_windows(input int w, input int nwin, input bit cont,
                               input int smode, input int vmode);
        int          cnt [32];
        int          n   = 0;
        int          got = 0;
        int          cyc = 0;
        bit          v;
        bit          end_now;
        logic [31:0] s;
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        while (got < nwin && cyc < 3000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            case (smode)
                0:       s = 32'h0000_0003;
                1:       s = 32'hFFFF_FFFF;
                2:       s = (n % 2 == 0) ? 32'h0000_0020 : 32'h0;
                default: s = $urandom;
            endcase
            spike_valid = v;
            spikes      = s;
            tick();
            cyc++;
            end_now = 1'b0;
            if (v) begin
                for (int i = 0; i < 32; i++) cnt[i] += int'(s[i]);
                n++;
                if (n == w) begin
                    end_now = 1'b1;
                    for (int i = 0; i < 32; i++) begin
                        exp_res[i] = (cnt[i] > 65535) ? 65535 : cnt[i];
                        cnt[i] = 0;
                    end
                    n = 0;
                    got++;
                end
            end
            vectors++;
            if (window_done !== end_now) begin
                miscompares++;
                $display("FAIL window_done cyc=%0d: got %b want %b", cyc, window_done, end_now);
            end
            vectors++;
            if (busy !== (cont || !end_now)) begin
                miscompares++;
                $display("FAIL busy_in_count cyc=%0d: got %b want %b", cyc, busy, (cont || !end_now));
            end
        end
        spike_valid = 1'b0;
        spikes      = '0;
        if (got < nwin) begin
            vectors++;
            miscompares++;
            $display("FAIL window_timeout: got %0d windows want %0d", got, nwin);
        end
    endtask

    task automatic test_reset();
        int          addrs [5] = '{0, 1, 2, 4, 35};
        logic [31:0] d;
        rst = 1'b1;
        bus.mem_addr = '0; bus.mem_wen = 1'b0; bus.mem_data_in = '0;
        sbus.mem_addr = '0; sbus.mem_wen = 1'b0; sbus.mem_data_in = '0;
        spikes = '0; spike_valid = 1'b0; s_spikes = '0; s_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            rd(addrs[k], d);
            vectors++;
            if (d !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_read addr=%0d: got %h want 0", addrs[k], d);
            end
        end
        vectors++;
        if (busy !== 1'b0 || window_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy=%b window_done=%b want 0 0", busy, window_done);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        wr(1, 32'd10);
        wr(0, 32'h1);
        run_windows(10, 1, 1'b0, 0, 1);
        for (int i = 0; i < 32; i++) begin
            rd(4 + i, d);
            vectors++;
            if (d !== 32'(exp_res[i])) begin
                miscompares++;
                $display("FAIL basic_result[%0d]: got %0d want %0d", i, d, exp_res[i]);
            end
        end
        rd(2, d);
        vectors++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL basic_status: got %h want 2", d);
        end
        rd(0, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL ctrl_reads_zero: got %h want 0", d);
        end
    endtask

    task automatic test_alternate();
        logic [31:0] d;
        wr(1, 32'd8);
        wr(0, 32'h1);
        run_windows(8, 1, 1'b0, 2, 0);
        rd(4 + 5, d);
        vectors++;
        if (d !== 32'(exp_res[5]) || exp_res[5] != 4) begin
            miscompares++;
            $display("FAIL alt_result5: got %0d want %0d", d, exp_res[5]);
        end
        rd(4 + 4, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL alt_result4: got %0d want 0", d);
        end
        wr(2, 32'h2);
        rd(2, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL done_clear: got %h want 0", d);
        end
    endtask

    task automatic test_continuous();
        logic [31:0] d;
        wr(1, 32'd4);
        wr(0, 32'h3);
        run_windows(4, 3, 1'b1, 1, 0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL cont_busy: got %b want 1", busy);
        end
        wr(0, 32'h4);
        vectors++;
        if (busy !== 1'b0 || window_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_flags: busy=%b window_done=%b want 0 0", busy, window_done);
        end
        for (int i = 0; i < 32; i++) begin
            rd(4 + i, d);
            vectors++;
            if (d !== 32'(exp_res[i])) begin
                miscompares++;
                $display("FAIL cont_result[%0d]: got %0d want %0d", i, d, exp_res[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int          w;
        for (int it = 0; it < 6; it++) begin
            w = int'($urandom_range(1, 30));
            wr(1, 32'(w));
            wr(0, 32'h1);
            run_windows(w, 1, 1'b0, 3, 2);
            rd(1, d);
            vectors++;
            if (d !== 32'(w)) begin
                miscompares++;
                $display("FAIL rand_window it=%0d: got %0d want %0d", it, d, w);
            end
            for (int i = 0; i < 32; i++) begin
                rd(4 + i, d);
                vectors++;
                if (d !== 32'(exp_res[i])) begin
                    miscompares++;
                    $display("FAIL rand_result it=%0d ch=%0d: got %0d want %0d", it, i, d, exp_res[i]);
                end
            end
        end
    endtask

    task automatic test_narrow();
        logic [31:0] d;
        bit          seen = 1'b0;
        s_valid  = 1'b0;
        s_spikes = 4'b0001;
        s_wr(1, 32'd15);
        s_wr(0, 32'h1);
        s_valid = 1'b1;
        s_wr(1, 32'd20);
        for (int k = 2; k <= 40 && !seen; k++) begin
            tick();
            if (s_wd) begin
                seen = 1'b1;
                vectors++;
                if (k != 15) begin
                    miscompares++;
                    $display("FAIL narrow_done_sample: got %0d want 15", k);
                end
            end
        end
        s_valid = 1'b0;
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL narrow_timeout: got no window_done want pulse");
        end
        s_rd(4, d);
        vectors++;
        if (d !== 32'd15) begin
            miscompares++;
            $display("FAIL narrow_result0: got %0d want 15", d);
        end
        s_rd(5, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL narrow_result1: got %0d want 0", d);
        end
        s_rd(1, d);
        vectors++;
        if (d !== 32'd15) begin
            miscompares++;
            $display("FAIL narrow_window_locked: got %0d want 15", d);
        end
        s_wr(1, 32'd0);
        s_wr(0, 32'h1);
        vectors++;
        if (s_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_window_start: busy got %b want 0", s_busy);
        end
        s_rd(2, d);
        vectors++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL narrow_status: got %h want 2", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(1, 32'd10);
        wr(0, 32'h1);
        spike_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            spikes = $urandom | 32'h1;
            tick();
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || window_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_flags: busy=%b window_done=%b want 0 0", busy, window_done);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            spikes = $urandom;
            tick();
            vectors++;
            if (busy !== 1'b0 || window_done !== 1'b0) begin
                miscompares++;
                $display("FAIL postreset_idle k=%0d: busy=%b window_done=%b want 0 0", k, busy, window_done);
            end
        end
        spike_valid = 1'b0;
        rd(1, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_window: got %0d want 0", d);
        end
        rd(2, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_status: got %h want 0", d);
        end
        for (int i = 0; i < 32; i++) begin
            rd(4 + i, d);
            vectors++;
            if (d !== 32'h0) begin
                miscompares++;
                $display("FAIL midreset_result[%0d]: got %0d want 0", i, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_continuous();
        test_random();
        test_narrow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Rate decoder for spike trains; the inverse of the Bernoulli spike encoder.
- Counts spikes per channel over a programmable window of qualified samples and latches per-channel counts, so the rate is count / WINDOW.
- Sits at the output of the SNN layer. Host reads results over the same word-addressed mem_* bus used by the encoder.

Parameters:
- NUM_SPIKES, 32, number of spike input channels (1..32)
- ADDR_WIDTH, 32, width of mem_addr
- DATA_WIDTH, 32, width of mem_data_in and mem_data_out
- COUNT_WIDTH, 16, width of each spike counter and of the sample counter (<= DATA_WIDTH)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- mem_addr  input  ADDR_WIDTH  word address of register access
- mem_wen  input  1  write enable for mem_data_in at mem_addr
- mem_data_in  input  DATA_WIDTH  write data
- mem_data_out  output  DATA_WIDTH  registered read data
- spikes  input  NUM_SPIKES  one bit per channel, sampled only when spike_valid=1
- spike_valid  input  1  qualifies spikes (encoder presents spikes every other cycle)
- busy  output  1  high while in COUNT
- window_done  output  1  one-cycle pulse when a window's results are latched

Behaviour:
- Register map (word addresses):
  - 0 CTRL (write-only, reads 0): bit0 start, bit1 continuous mode (stored), bit2 abort.
  - 1 WINDOW: R/W, low COUNT_WIDTH bits are the number of qualified samples per window.
  - 2 STATUS: bit0 busy, bit1 done (sticky); writing 1 to bit1 clears done.
  - 4..4+NUM_SPIKES-1 RESULT[i]: read-only latched count, zero-extended.
  - All other addresses read 0; writes to them are ignored.
- Read timing: mem_data_out updates on every rising edge with the value at mem_addr before that edge's updates. Latency 1 cycle.
- Reset values: mem_data_out=0, busy=0, window_done=0, WINDOW=0, continuous=0, done=0. All working counters and RESULT registers are 0. FSM enters IDLE.
- FSM states IDLE, COUNT.
  - IDLE -> COUNT: CTRL write with bit0=1 and WINDOW != 0. Clears the sample counter and working counters.
  - Start with WINDOW=0: ignored, FSM stays in IDLE.
  - Start while in COUNT: ignored.
- In COUNT, on each cycle with spike_valid=1:
  - Sample counter increments.
  - Each working counter i with spikes[i]=1 increments, saturating at 2^COUNT_WIDTH-1.
  - spike_valid=0: no counter changes.
- Window end: qualified sample that makes the sample count equal WINDOW.
  - The final sample's spikes are included in the count.
  - RESULT[i] <= working count including that sample.
  - Working counters and sample counter clear; window_done pulses the next cycle; done <= 1.
  - continuous=1: remain in COUNT with no dead cycle; the next qualified sample counts toward the new window.
  - continuous=0: go to IDLE.
- Abort: CTRL bit2=1 in COUNT -> IDLE, working counters cleared, RESULT and done unchanged, no window_done.
  - Abort has priority over start in the same write.
  - Abort on the same edge as window end: the latch still happens, then go to IDLE.
- WINDOW writes while busy=1 are ignored.
- Simultaneous done clear and window end: set wins, done=1.
- busy=1 exactly while state is COUNT.
- rst asserted mid-window: immediate return to reset values. Results are lost.

Test Plan:
- Reset, then read addresses 0,1,2,4,35 -> each returns 0 one cycle after address presented; busy=0.
- WINDOW=10, start, spike_valid toggling each cycle, spikes=32'h0000_0003 always -> window_done after 10th valid sample (~20 cycles); RESULT[0]=RESULT[1]=10, RESULT[2..31]=0; STATUS=2; busy=0.
- WINDOW=8, spikes[5] high on alternate valid samples starting with first, spike_valid=1 -> RESULT[5]=4; write STATUS=2 -> STATUS reads 0.
- Continuous mode, WINDOW=4, spikes=all ones, spike_valid=1 -> window_done pulses every 4 cycles; each RESULT=4; busy stays 1; abort -> busy=0 next cycle, RESULTs stay 4.
- COUNT_WIDTH=4, WINDOW=15 then 20 (write while busy ignored), spikes[0]=1 always -> RESULT[0]=15; start with WINDOW=0 -> busy stays 0.
- Assert rst at valid sample 3 of 10 -> busy=0, all RESULT=0, WINDOW=0, no window_done.
